// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard / freeze controller for a 5-stage in-order core
//            with branches resolving in ID. Detects load-use and
//            branch-operand hazards, inserts ID/EX bubbles, freezes the
//            whole pipe on cache misses, and flushes IF/ID on redirects
//            (remembering redirects that arrive while frozen).
// Ports    : clk, rst                       - clock, sync active-high reset
//            id_rs1/rs2, id_use_rs1/rs2     - ID source operands
//            id_branch, redirect            - ID branch / taken redirect
//            ex_rd, ex_regwrite, ex_memread - EX destination and control
//            mem_rd, mem_memread            - MEM destination and load flag
//            icache_stall, dcache_stall     - cache miss in progress
//            pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold
//                                           - pipeline control (combinational)
//            stall_cycles, freeze_cycles    - saturating perf counters
// Config   : HAZ_PERF_CNT_EN - when defined, counters are implemented;
//            otherwise both counter ports read 0 and no flops exist.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_branch,
    input  logic             redirect,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_memread,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HAZ    = 2'd1,
        S_FREEZE = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt, w_eff_state;
    logic [1:0] r_stall_left, w_stall_left_nxt;
    logic       r_ret_haz, w_ret_haz_nxt;
    logic       r_flush_pending, w_flush_pending_nxt;

    logic       w_match_ex, w_match_mem, w_freeze;
    logic [1:0] w_need;

    assign w_freeze = icache_stall | dcache_stall;

    // Register 0 never creates a dependency.
    assign w_match_ex  = (ex_rd != 5'd0) &&
                         ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                          (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_match_mem = (mem_rd != 5'd0) &&
                         ((id_use_rs1 && (id_rs1 == mem_rd)) ||
                          (id_use_rs2 && (id_rs2 == mem_rd)));

    // Branch compares in ID, so a branch needs its operand one stage earlier
    // than an ALU op: load in EX costs two bubbles, ALU op in EX or load in
    // MEM costs one.
    always_comb begin
        w_need = 2'd0;
        if (id_branch && ex_memread && w_match_ex)
            w_need = 2'd2;
        else if (!id_branch && ex_memread && w_match_ex)
            w_need = 2'd1;
        else if (id_branch && ex_regwrite && !ex_memread && w_match_ex)
            w_need = 2'd1;
        else if (id_branch && mem_memread && w_match_mem)
            w_need = 2'd1;
    end

    // While frozen the state register remembers where to resume; the exit
    // cycle behaves exactly like that resume state. Reset forces RUN rules.
    always_comb begin
        if (rst)
            w_eff_state = S_RUN;
        else if (r_state == S_FREEZE)
            w_eff_state = r_ret_haz ? S_HAZ : S_RUN;
        else
            w_eff_state = r_state;
    end

    always_comb begin
        pc_write            = 1'b1;
        if_id_write         = 1'b1;
        if_id_flush         = 1'b0;
        id_ex_bubble        = 1'b0;
        pipe_hold           = 1'b0;
        w_state_nxt         = r_state;
        w_stall_left_nxt    = r_stall_left;
        w_ret_haz_nxt       = r_ret_haz;
        w_flush_pending_nxt = r_flush_pending;

        if (w_freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_hold     = 1'b1;
            w_state_nxt   = S_FREEZE;
            w_ret_haz_nxt = (r_state == S_FREEZE) ? r_ret_haz : (r_state == S_HAZ);
            if (redirect)
                w_flush_pending_nxt = 1'b1;
        end else if (w_eff_state == S_HAZ) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (r_stall_left != 2'd0)
                w_stall_left_nxt = r_stall_left - 2'd1;
            w_state_nxt = (r_stall_left <= 2'd1) ? S_RUN : S_HAZ;
        end else if (w_need != 2'd0) begin
            // Redirect is ignored while stalling: the branch is re-evaluated
            // once its operands are ready.
            pc_write         = 1'b0;
            if_id_write      = 1'b0;
            id_ex_bubble     = 1'b1;
            w_stall_left_nxt = w_need - 2'd1;
            w_state_nxt      = (w_need == 2'd2) ? S_HAZ : S_RUN;
        end else begin
            w_state_nxt = S_RUN;
            if (redirect || r_flush_pending) begin
                if_id_flush         = 1'b1;
                w_flush_pending_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_RUN;
            r_stall_left    <= 2'd0;
            r_ret_haz       <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_stall_left    <= w_stall_left_nxt;
            r_ret_haz       <= w_ret_haz_nxt;
            r_flush_pending <= w_flush_pending_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_freeze_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (id_ex_bubble && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (pipe_hold && (r_freeze_cnt != {CNT_W{1'b1}}))
                r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles  = r_stall_cnt;
    assign freeze_cycles = r_freeze_cnt;
`else
    assign stall_cycles  = '0;
    assign freeze_cycles = '0;
`endif

endmodule
`default_nettype wire
